// File: rtl/inst_mem_loader_pkg.sv
// Shared types and helpers for the L1 instruction memory and its burst loader.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_RANGE = 2'b01,
        FC_ALIGN = 2'b10,
        FC_BUSY  = 2'b11
    } fault_cause_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } load_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Subtraction form avoids overflow of base+span near the top of the address space.
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Fetch port (PC side) and loader stream port (host/DMA side) of the instruction memory.
interface inst_mem_loader_if #(
    parameter int XLEN   = 64,
    parameter int INST_W = 32
);
    import inst_mem_pkg::*;

    logic              fetch_en;
    logic [XLEN-1:0]   pc_if;
    logic [INST_W-1:0] inst_if;
    logic              inst_valid;
    logic              inst_fault;
    logic [1:0]        fault_cause;

    // Loader stream: a word moves on every cycle where load_valid and load_ready are both high;
    // load_valid/load_data/load_last must stay stable until then, load_ready never waits on load_valid.
    logic              load_start;
    logic [XLEN-1:0]   load_addr;
    logic              load_valid;
    logic              load_last;
    logic [INST_W-1:0] load_data;
    logic              load_ready;
    logic              load_busy;
    logic              load_err;

    load_state_e       state_dbg;

    modport master (
        output fetch_en, pc_if, load_start, load_addr, load_valid, load_last, load_data,
        input  inst_if, inst_valid, inst_fault, fault_cause, load_ready, load_busy, load_err,
               state_dbg
    );

    modport slave (
        input  fetch_en, pc_if, load_start, load_addr, load_valid, load_last, load_data,
        output inst_if, inst_valid, inst_fault, fault_cause, load_ready, load_busy, load_err,
               state_dbg
    );

endinterface

// File: rtl/inst_mem_loader_ram.sv
// DEPTH x INST_W array, one write port and one synchronous read port (block RAM shape).
module inst_mem_ram #(
    parameter int DEPTH  = 128,
    parameter int INST_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];
    logic [INST_W-1:0] rdata_q, rdata_d;

    // Read register holds its value when no read is requested (stall and fault cycles).
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_loader.sv
// L1 instruction memory: registered IF fetch with fault reporting plus a burst program loader.
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              INST_W    = 32,
    parameter int              DEPTH     = 128,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter bit              ALIGN_CHK = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    inst_mem_loader_if.slave   bus
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(4 * DEPTH);

    load_state_e  state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;
    fault_cause_e  cause_q, cause_d;

    logic          pc_ok, start_ok, start_acc, busy;
    logic [AW-1:0] pc_idx, start_idx;
    logic          ram_we, ram_re;

    assign pc_ok     = in_range(64'(bus.pc_if), 64'(BASE_ADDR), SPAN);
    assign pc_idx    = AW'((bus.pc_if - BASE_ADDR) >> 2);
    assign start_ok  = in_range(64'(bus.load_addr), 64'(BASE_ADDR), SPAN)
                       && (bus.load_addr[1:0] == 2'b00);
    assign start_idx = AW'((bus.load_addr - BASE_ADDR) >> 2);
    assign start_acc = (state_q == ST_IDLE) && bus.load_start && start_ok;
    // The cycle a start is accepted already counts as busy so a fetch never races the first write.
    assign busy      = (state_q == ST_LOAD) || start_acc;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    if (start_ok) begin
                        state_d = ST_LOAD;
                        idx_d   = start_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.load_valid) begin
                    ram_we = rstn;
                    idx_d  = idx_q + AW'(1);
                    if (bus.load_last) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == AW'(DEPTH - 1)) begin
                        // Top word written without load_last: stop rather than wrap onto word 0.
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        fault_d = 1'b0;
        cause_d = FC_NONE;
        ram_re  = 1'b0;
        if (!bus.fetch_en) begin
            cause_d = FC_NONE;
        end else if (!pc_ok) begin
            fault_d = 1'b1;
            cause_d = FC_RANGE;
        end else if (ALIGN_CHK && (bus.pc_if[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            cause_d = FC_ALIGN;
        end else if (busy) begin
            fault_d = 1'b1;
            cause_d = FC_BUSY;
        end else begin
            ram_re  = 1'b1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    inst_mem_ram #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (bus.load_data),
        .re    (ram_re),
        .raddr (pc_idx),
        .rdata (bus.inst_if)
    );

    assign bus.inst_valid  = valid_q;
    assign bus.inst_fault  = fault_q;
    assign bus.fault_cause = cause_q;
    assign bus.load_ready  = (state_q == ST_LOAD);
    assign bus.load_busy   = (state_q == ST_LOAD);
    assign bus.load_err    = err_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: fetch results scoreboarded against a reference image of the array.
module tb_inst_mem_loader;
    import inst_mem_pkg::*;

    localparam int DEPTH = 128;
    localparam int EXP_W = 36;

    logic clk;
    logic rstn;

    inst_mem_loader_if #(.XLEN(64), .INST_W(32)) bus0 ();
    inst_mem_loader_if #(.XLEN(64), .INST_W(32)) bus1 ();

    inst_mem_loader #(
        .XLEN(64), .INST_W(32), .DEPTH(DEPTH), .BASE_ADDR(64'h0), .ALIGN_CHK(1'b1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0)
    );

    // Second copy without alignment checking sees the same inputs.
    inst_mem_loader #(
        .XLEN(64), .INST_W(32), .DEPTH(DEPTH), .BASE_ADDR(64'h0), .ALIGN_CHK(1'b0)
    ) dut_na (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    assign bus1.fetch_en   = bus0.fetch_en;
    assign bus1.pc_if      = bus0.pc_if;
    assign bus1.load_start = bus0.load_start;
    assign bus1.load_addr  = bus0.load_addr;
    assign bus1.load_valid = bus0.load_valid;
    assign bus1.load_last  = bus0.load_last;
    assign bus1.load_data  = bus0.load_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_inst = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_load(input string tag, input bit rdy, input bit bsy, input bit err);
        check_val({tag, "_ready"}, 64'(bus0.load_ready), 64'(rdy));
        check_val({tag, "_busy"},  64'(bus0.load_busy),  64'(bsy));
        check_val({tag, "_err"},   64'(bus0.load_err),   64'(err));
    endtask

    // One clock: drive at negedge, predict the fetch result, compare #1 after the posedge.
    task automatic step(input bit fen, input logic [63:0] pc, input bit busy_exp,
                        input bit ls, input logic [63:0] la, input bit lv, input bit ll,
                        input logic [31:0] ld);
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] g;
        @(negedge clk);
        bus0.fetch_en   = fen;
        bus0.pc_if      = pc;
        bus0.load_start = ls;
        bus0.load_addr  = la;
        bus0.load_valid = lv;
        bus0.load_last  = ll;
        bus0.load_data  = ld;
        if (!fen) begin
            e = {exp_inst, 1'b0, 1'b0, 2'b00};
        end else if (pc >= 64'h200) begin
            e = {exp_inst, 1'b0, 1'b1, 2'b01};
        end else if (pc[1:0] != 2'b00) begin
            e = {exp_inst, 1'b0, 1'b1, 2'b10};
        end else if (busy_exp) begin
            e = {exp_inst, 1'b0, 1'b1, 2'b11};
        end else begin
            exp_inst = ref_mem[pc[8:2]];
            e = {exp_inst, 1'b1, 1'b0, 2'b00};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            g = {bus0.inst_if, bus0.inst_valid, bus0.inst_fault, bus0.fault_cause};
            check_val("inst",  64'(g[35:4]), 64'(e[35:4]));
            check_val("valid", 64'(g[3]),    64'(e[3]));
            check_val("fault", 64'(g[2]),    64'(e[2]));
            check_val("cause", 64'(g[1:0]),  64'(e[1:0]));
        end
    endtask

    task automatic fetch(input logic [63:0] pc);
        step(1'b1, pc, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Burst of n words from addr; words past the top of the array are offered but must not move.
    task automatic load_burst(input logic [63:0] addr, input int n, input bit use_last,
                              input bit rnd, input logic [31:0] dbase,
                              input bit fen, input logic [63:0] fpc);
        int   widx;
        bit   active;
        bit   last;
        bit   ovf;
        logic [31:0] d;
        step(fen, fpc, 1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0);
        check_load("start", 1'b1, 1'b1, 1'b0);
        active = 1'b1;
        for (int i = 0; i < n; i++) begin
            d    = rnd ? 32'($urandom) : dbase + 32'(i);
            last = use_last && (i == n - 1);
            if (active) begin
                widx = int'(addr >> 2) + i;
                step(fen, fpc, 1'b1, 1'b0, 64'h0, 1'b1, last, d);
                ref_mem[widx] = d;
                ovf    = (widx == DEPTH - 1) && !last;
                active = !(last || ovf);
                check_load("xfer", active, active, ovf);
            end else begin
                step(fen, fpc, 1'b0, 1'b0, 64'h0, 1'b1, last, d);
                check_load("post", 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        rstn            = 1'b0;
        bus0.fetch_en   = 1'b0;
        bus0.pc_if      = '0;
        bus0.load_start = 1'b0;
        bus0.load_addr  = '0;
        bus0.load_valid = 1'b0;
        bus0.load_last  = 1'b0;
        bus0.load_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_inst",  64'(bus0.inst_if),     64'h0);
        check_val("rst_valid", 64'(bus0.inst_valid),  64'h0);
        check_val("rst_fault", 64'(bus0.inst_fault),  64'h0);
        check_val("rst_cause", 64'(bus0.fault_cause), 64'h0);
        check_load("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Short burst with a fetch during the start cycle, then fill the rest of the array.
        load_burst(64'h0, 4, 1'b1, 1'b0, 32'hA0, 1'b1, 64'h0);
        load_burst(64'h10, DEPTH - 4, 1'b1, 1'b1, 32'h0, 1'b0, 64'h0);
        fetch(64'h8);
        check_val("a2_word", 64'(bus0.inst_if), 64'hA2);

        fetch(64'h200);
        fetch(64'h1FC);
        fetch(64'h6);
        check_val("na_inst",  64'(bus1.inst_if),    64'(ref_mem[1]));
        check_val("na_valid", 64'(bus1.inst_valid), 64'h1);
        fetch(64'h0);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 64'($urandom_range(0, 16'h1FF)), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        end

        for (int i = 0; i < 24; i++) begin
            step(($urandom_range(0, 3) != 0), 64'($urandom_range(0, 16'h27F)), 1'b0,
                 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        end

        // Rejected starts: misaligned, then just past the array.
        step(1'b1, 64'h8, 1'b0, 1'b1, 64'h202, 1'b0, 1'b0, 32'h0);
        check_load("bad_mis", 1'b0, 1'b0, 1'b1);
        fetch(64'h4);
        check_load("bad_clr", 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h8, 1'b0, 1'b1, 64'h200, 1'b0, 1'b0, 32'h0);
        check_load("bad_rng", 1'b0, 1'b0, 1'b1);

        // Overflow burst at the top of the array while fetching the last word.
        load_burst(64'h1F8, 3, 1'b0, 1'b1, 32'h0, 1'b1, 64'h1FC);
        fetch(64'h0);
        check_val("no_wrap", 64'(bus0.inst_if), 64'hA0);
        fetch(64'h1F8);

        // Reset in the middle of a burst after two words.
        load_burst(64'h40, 2, 1'b0, 1'b1, 32'h0, 1'b0, 64'h0);
        @(negedge clk);
        rstn            = 1'b0;
        bus0.load_valid = 1'b0;
        bus0.fetch_en   = 1'b1;
        bus0.pc_if      = 64'h40;
        @(posedge clk);
        #1;
        exp_inst = '0;
        check_val("mrst_inst",  64'(bus0.inst_if),     64'h0);
        check_val("mrst_valid", 64'(bus0.inst_valid),  64'h0);
        check_val("mrst_fault", 64'(bus0.inst_fault),  64'h0);
        check_val("mrst_cause", 64'(bus0.fault_cause), 64'h0);
        check_load("mrst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        fetch(64'h40);
        fetch(64'h44);
        check_load("after_rst", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
